// File: rtl/stack_seq_pkg.sv
// Shared types and defaults for the stack_seq request sequencer.
// STACK_SEQ_PEEK_EN adds the PEEK op and its write-back state.
package stack_seq_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [2:0] {
        OP_PUSH_DATA = 3'b000,
        OP_PUSH_PC   = 3'b001,
        OP_POP       = 3'b010,
        OP_CLEAR     = 3'b011,
        OP_PEEK      = 3'b100
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_DEC  = 3'd2,
        S_RD   = 3'd3,
`ifdef STACK_SEQ_PEEK_EN
        S_WB   = 3'd4,
`endif
        S_CLR  = 3'd5,
        S_RESP = 3'd6
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        ok = (op == OP_PUSH_DATA) || (op == OP_PUSH_PC) ||
             (op == OP_POP) || (op == OP_CLEAR);
`ifdef STACK_SEQ_PEEK_EN
        ok = ok || (op == OP_PEEK);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/stack_seq_level.sv
// Saturating shadow entry counter for stack_seq; clear wins over inc/dec.
module stack_seq_level #(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [LVL_W-1:0] level
);

    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            level <= '0;
        end else if (inc && !dec && level != MAX_LVL) begin
            level <= level + 1'b1;
        end else if (dec && !inc && level != '0) begin
            level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/stack_seq.sv
// Single-outstanding request sequencer driving a LIFO stack's control pins.
// Build with STACK_SEQ_PEEK_EN to enable the PEEK op (DEC -> RD -> WB).
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    input  logic [DATA_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [LVL_W-1:0]  level,
    output logic              stk_reset,
    output logic              stk_push,
    output logic              stk_pop,
    output logic              stk_we,
    output logic              stk_re,
    output logic              stk_mux_sel,
    output logic [DATA_W-1:0] stk_data_1,
    output logic [DATA_W-1:0] stk_data_2,
    input  logic [DATA_W-1:0] stk_data_out,
    input  logic              stk_full,
    input  logic              stk_empty,
    output logic [2:0]        fsm_state
);

    state_t            state;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] pc_q;
    logic              in_wb;
    logic              is_push;
    logic              is_read;
    logic              req_err;

    // Handshakes: a request transfers on a clk edge with req_valid && req_ready;
    // a response is held stable from rsp_valid until the edge with rsp_ready.
    assign req_ready = (state == S_IDLE);
    assign fsm_state = state;

    assign is_push = (req_op == OP_PUSH_DATA) || (req_op == OP_PUSH_PC);
`ifdef STACK_SEQ_PEEK_EN
    assign is_read = (req_op == OP_POP) || (req_op == OP_PEEK);
    assign in_wb   = (state == S_WB);
`else
    assign is_read = (req_op == OP_POP);
    assign in_wb   = 1'b0;
`endif
    assign req_err = !op_legal(req_op) || (is_push && stk_full) || (is_read && stk_empty);

    // Stack-side pins depend on the state register only (plus rst for the reset pin).
    assign stk_reset   = rst || (state == S_CLR);
    assign stk_push    = (state == S_WR) || in_wb;
    assign stk_we      = (state == S_WR) || in_wb;
    assign stk_pop     = (state == S_DEC);
    assign stk_re      = (state == S_RD);
    assign stk_mux_sel = in_wb || ((state == S_WR) && (op_q == OP_PUSH_DATA));
    assign stk_data_1  = in_wb ? rsp_data : data_q;
    assign stk_data_2  = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            data_q    <= '0;
            pc_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        data_q <= req_data;
                        pc_q   <= req_pc;
                        if (req_err) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else if (is_push) begin
                            state <= S_WR;
                        end else if (is_read) begin
                            state <= S_DEC;
                        end else begin
                            state <= S_CLR;
                        end
                    end
                end
                S_WR: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                end
                S_DEC: state <= S_RD;
                S_RD: begin
                    rsp_data <= stk_data_out;
`ifdef STACK_SEQ_PEEK_EN
                    if (op_q == OP_PEEK) begin
                        state <= S_WB;
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                    end
`else
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
`endif
                end
`ifdef STACK_SEQ_PEEK_EN
                S_WB: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                end
`endif
                S_CLR: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    stack_seq_level #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_level (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == S_CLR),
        .inc   ((state == S_WR) || in_wb),
        .dec   (state == S_DEC),
        .level (level)
    );

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: behavioural stack on the pin side, queue model for expectations.
// Honours STACK_SEQ_PEEK_EN the same way as the design.
module tb_stack_seq;
    import stack_seq_pkg::*;

    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int LW    = 5;
    localparam logic [LW-1:0] FULL_PTR = 5'd16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = 3'd0;
    logic [DW-1:0] req_data = '0;
    logic [DW-1:0] req_pc = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [LW-1:0] level;
    logic          stk_reset, stk_push, stk_pop, stk_we, stk_re, stk_mux_sel;
    logic [DW-1:0] stk_data_1, stk_data_2, stk_data_out;
    logic          stk_full, stk_empty;
    logic [2:0]    fsm_state;

    always #5 clk = ~clk;

    stack_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .level(level),
        .stk_reset(stk_reset), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_we(stk_we), .stk_re(stk_re), .stk_mux_sel(stk_mux_sel),
        .stk_data_1(stk_data_1), .stk_data_2(stk_data_2), .stk_data_out(stk_data_out),
        .stk_full(stk_full), .stk_empty(stk_empty),
        .fsm_state(fsm_state)
    );

    // Pin-level stack the sequencer drives.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [LW-1:0] ptr = '0;

    always @(posedge clk) begin
        if (stk_reset) begin
            ptr <= '0;
        end else if (stk_push) begin
            if (ptr < FULL_PTR) begin
                if (stk_we) mem[ptr[3:0]] <= stk_mux_sel ? stk_data_1 : stk_data_2;
                ptr <= ptr + 1'b1;
            end
        end else if (stk_pop && ptr != '0) begin
            ptr <= ptr - 1'b1;
        end
    end

    assign stk_data_out = (ptr < FULL_PTR) ? mem[ptr[3:0]] : '0;
    assign stk_full     = (ptr == FULL_PTR);
    assign stk_empty    = (ptr == '0);

    // Running pulse totals; transactions look at differences.
    int   tot_we = 0, tot_pop = 0, tot_rst = 0;
    logic last_mux = 1'b0;

    always @(negedge clk) begin
        if (stk_we) begin
            tot_we++;
            last_mux = stk_mux_sel;
        end
        if (stk_pop) tot_pop++;
        if (stk_reset) tot_rst++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] exp_q[$];

    task automatic do_op(input logic [2:0] op, input logic [DW-1:0] d, input logic [DW-1:0] pc,
                         input int hold);
        logic          e_err;
        logic [DW-1:0] e_data;
        int            e_lat, e_we, e_pop, e_rst;
        logic          e_mux;
        int            we0, pop0, rst0, lat, g;
        logic          got;
        logic [DW-1:0] d_hold;
        logic          err_hold;

        e_err = 1'b0; e_data = '0; e_we = 0; e_pop = 0; e_rst = 0; e_mux = 1'b0; e_lat = 1;
        case (op)
            3'd0, 3'd1: begin
                if (exp_q.size() == DEPTH) e_err = 1'b1;
                else begin
                    exp_q.push_back(op == 3'd0 ? d : pc);
                    e_lat = 2; e_we = 1; e_mux = (op == 3'd0);
                end
            end
            3'd2: begin
                if (exp_q.size() == 0) e_err = 1'b1;
                else begin
                    e_data = exp_q.pop_back();
                    e_lat = 3; e_pop = 1;
                end
            end
            3'd3: begin
                exp_q.delete();
                e_lat = 2; e_rst = 1;
            end
`ifdef STACK_SEQ_PEEK_EN
            3'd4: begin
                if (exp_q.size() == 0) e_err = 1'b1;
                else begin
                    e_data = exp_q[exp_q.size()-1];
                    e_lat = 4; e_pop = 1; e_we = 1; e_mux = 1'b1;
                end
            end
`endif
            default: e_err = 1'b1;
        endcase

        @(negedge clk);
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_data = d; req_pc = pc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = DW'($urandom_range(0, 15));
        req_pc    = DW'($urandom_range(0, 15));
        we0 = tot_we; pop0 = tot_pop; rst0 = tot_rst;

        lat = 0; got = 1'b0;
        while (lat < 8 && !got) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        check("rsp_arrives", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(e_lat));
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        check("rsp_data", 32'(rsp_data), 32'(e_data));
        check("level", 32'(level), 32'(exp_q.size()));
        check("we_pulses", 32'(tot_we - we0), 32'(e_we));
        check("pop_pulses", 32'(tot_pop - pop0), 32'(e_pop));
        check("reset_pulses", 32'(tot_rst - rst0), 32'(e_rst));
        if (e_we != 0) check("mux_sel", 32'(last_mux), 32'(e_mux));

        d_hold = rsp_data; err_hold = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", 32'(rsp_data), 32'(d_hold));
            check("hold_err", 32'(rsp_err), 32'(err_hold));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_cleared", {30'd0, rsp_valid, rsp_err}, 32'd0);
        check("rsp_data_cleared", 32'(rsp_data), 32'd0);
        check("req_ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        logic [2:0] op;

        // Reset behaviour
        repeat (3) @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_stk_reset", 32'(stk_reset), 32'd1);
        check("rst_stk_ctl", {28'd0, stk_push, stk_pop, stk_we, stk_re}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_stk_reset", 32'(stk_reset), 32'd0);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_state", 32'(fsm_state), 32'(S_IDLE));

        // Push data then PC, pop both back, pop once more into underflow
        do_op(3'd0, 4'hA, 4'h0, 0);
        do_op(3'd1, 4'h0, 4'h3, 0);
        check("level_two", 32'(level), 32'd2);
        do_op(3'd2, 4'h0, 4'h0, 0);
        do_op(3'd2, 4'h0, 4'h0, 0);
        do_op(3'd2, 4'h0, 4'h0, 0);

        // Fill to capacity, then overflow
        for (int i = 0; i < DEPTH; i++) do_op(3'd0, DW'(i), 4'h0, 0);
        check("level_full", 32'(level), 32'd16);
        do_op(3'd0, 4'h9, 4'h0, 0);

        // Back-pressure on the response
        do_op(3'd2, 4'h0, 4'h0, 5);

        // Down to five entries, clear, then underflow
        for (int i = 0; i < 10; i++) do_op(3'd2, 4'h0, 4'h0, 0);
        check("level_five", 32'(level), 32'd5);
        do_op(3'd3, 4'h0, 4'h0, 0);
        do_op(3'd2, 4'h0, 4'h0, 0);

        // PEEK of top 0x7 (error when the option is compiled out)
        do_op(3'd0, 4'h7, 4'h0, 0);
        do_op(3'd4, 4'h0, 4'h0, 0);
        do_op(3'd2, 4'h0, 4'h0, 0);

        // Illegal opcodes
        for (int i = 5; i < 8; i++) do_op(3'(i), 4'h1, 4'h2, 0);

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 19);
            if (r < 7)       op = 3'd0;
            else if (r < 10) op = 3'd1;
            else if (r < 16) op = 3'd2;
            else if (r == 16) op = 3'd3;
            else if (r < 19) op = 3'd4;
            else             op = 3'($urandom_range(5, 7));
            do_op(op, DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)),
                  $urandom_range(0, 2));
        end

        // Reset during the DEC cycle of a POP
        do_op(3'd0, 4'h5, 4'h0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_dec", 32'(stk_pop), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_stk_reset", 32'(stk_reset), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
            check("abort_level", 32'(level), 32'd0);
            check("abort_req_ready", 32'(req_ready), 32'd1);
        end
        do_op(3'd2, 4'h0, 4'h0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
